serial_adder_ctrl: RTL

- Bit-serial add/subtract engine: one full-adder cell (two half-adder stages plus an OR for carry) is reused once per bit over WIDTH cycles.
- The block owns the operand shift registers, the carry flip-flop, the bit counter and the start/done handshake.
- It sits between a register-file style requester and the shared 1-bit adder cell, trading area for latency.

---
 rtl/serial_adder_ctrl.sv | 124 ++++++++++++
 1 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial add/subtract engine.
// One full-adder cell (two half-adder stages plus an OR for the carry) is
// reused once per bit over WIDTH cycles, LSB first. The block owns the
// operand shift registers, the carry flop, the bit counter and the
// start/done handshake. Results are registered and held until the next
// completion or reset.
module serial_adder_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int unsigned   CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry_out;
  logic             r_overflow;

  logic             w_hx;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  // Shared 1-bit full adder plus the accumulator shift-in of the new bit.
  // The MSB insert is done by index rather than a concatenation so that the
  // WIDTH=1 build never forms a reversed slice.
  always_comb begin
    w_hx       = r_opa[0] ^ r_opb[0];
    w_s        = w_hx ^ r_carry;
    w_c        = (r_opa[0] & r_opb[0]) | (r_carry & w_hx);
    w_last     = (r_cnt == LAST);
    w_acc_next = r_acc >> 1;
    w_acc_next[WIDTH-1] = w_s;
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_opa       <= '0;
      r_opb       <= '0;
      r_acc       <= '0;
      r_carry     <= 1'b0;
      r_cnt       <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_sum       <= '0;
      r_carry_out <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: the +1 enters as the initial carry.
            r_opa   <= a;
            r_opb   <= sub ? ~b : b;
            r_carry <= sub;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          r_carry <= w_c;
          r_acc   <= w_acc_next;
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            // On the MSB step r_carry is the carry into the MSB and w_c the
            // carry out of it; their XOR is signed overflow.
            r_sum       <= w_acc_next;
            r_carry_out <= w_c;
            r_overflow  <= r_carry ^ w_c;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= DONE;
          end
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign sum       = r_sum;
  assign carry_out = r_carry_out;
  assign overflow  = r_overflow;

endmodule
